// File: rtl/matrix_pkg.sv
// Shared types and constants for the 4x4 block matrix multiplier datapath.
// Element width is fixed here at 2*WIDTH with WIDTH=16; the controller re-derives it from its own parameter.
package matrix_pkg;

    localparam int N      = 4;
    localparam int WIDTH  = 16;
    localparam int ELEM_W = 2 * WIDTH;

    typedef logic [ELEM_W-1:0] elem_t;
    typedef elem_t [N-1:0][N-1:0] mat4_t;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD_A  = 3'd1,
        LOAD_B  = 3'd2,
        COMPUTE = 3'd3,
        DRAIN   = 3'd4
    } state_t;

endpackage

// File: rtl/matrix_stream_ctrl.sv
// Stream front/back end for the 4x4 multiplier: deserialises A and B, holds them for a
// fixed compute window, captures C and re-serialises it row-major onto a valid/ready stream.
module matrix_stream_ctrl
    import matrix_pkg::*;
#(
    parameter int WIDTH       = 16,
    parameter int MUL_LATENCY = 12
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [2*WIDTH-1:0]                 s_data,
    input  logic                               s_valid,
    output logic                               s_ready,
    input  logic [4:0]                         m_bit1_in,
    input  logic [4:0]                         m_bit2_in,
    output logic [N-1:0][N-1:0][2*WIDTH-1:0]   A,
    output logic [N-1:0][N-1:0][2*WIDTH-1:0]   B,
    output logic [4:0]                         m_bit1,
    output logic [4:0]                         m_bit2,
    output logic                               flag,
    input  logic [N-1:0][N-1:0][2*WIDTH-1:0]   C,
    output logic [2*WIDTH-1:0]                 m_data,
    output logic                               m_valid,
    input  logic                               m_ready,
    output logic                               m_last,
    output logic                               busy
);

    localparam int              LAT_W    = $clog2(MUL_LATENCY + 1);
    localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(MUL_LATENCY - 1);

    state_t                             state;
    logic [3:0]                         idx;
    logic [3:0]                         idx_next;
    logic [LAT_W-1:0]                   lat_cnt;
    logic [N-1:0][N-1:0][2*WIDTH-1:0]   c_cap;
    logic                               s_fire;
    logic                               m_fire;

    assign s_ready  = (state == IDLE) || (state == LOAD_A) || (state == LOAD_B);
    assign flag     = (state == COMPUTE);
    assign busy     = (state != IDLE);
    assign s_fire   = s_valid & s_ready;
    assign m_fire   = m_valid & m_ready;
    assign idx_next = idx + 4'd1;

    // NOTE: every register below is written with <= so all of them see the pre-edge values of
    // state/idx; a blocking assignment here would let later statements observe the new state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            idx     <= 4'd0;
            lat_cnt <= '0;
            // NOTE: the operand and capture arrays are cleared too, so a reset mid-job leaves
            // nothing of the aborted job visible on A/B and nothing to replay on m_data.
            A       <= '0;
            B       <= '0;
            c_cap   <= '0;
            m_bit1  <= 5'd0;
            m_bit2  <= 5'd0;
            m_data  <= '0;
            m_valid <= 1'b0;
            m_last  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (s_fire) begin
                        A[0][0] <= s_data;
                        m_bit1  <= m_bit1_in;
                        m_bit2  <= m_bit2_in;
                        idx     <= 4'd1;
                        state   <= LOAD_A;
                    end
                end

                LOAD_A: begin
                    if (s_fire) begin
                        A[idx[3:2]][idx[1:0]] <= s_data;
                        idx                   <= idx_next;
                        if (idx == 4'd15) state <= LOAD_B;
                    end
                end

                LOAD_B: begin
                    if (s_fire) begin
                        B[idx[3:2]][idx[1:0]] <= s_data;
                        idx                   <= idx_next;
                        if (idx == 4'd15) begin
                            lat_cnt <= LAT_LOAD;
                            state   <= COMPUTE;
                        end
                    end
                end

                COMPUTE: begin
                    if (lat_cnt == '0) begin
                        // First result beat is loaded straight from C on the capture edge.
                        c_cap   <= C;
                        m_data  <= C[0][0];
                        m_valid <= 1'b1;
                        m_last  <= 1'b0;
                        idx     <= 4'd0;
                        state   <= DRAIN;
                    end else begin
                        lat_cnt <= lat_cnt - LAT_W'(1);
                    end
                end

                DRAIN: begin
                    if (m_fire) begin
                        if (idx == 4'd15) begin
                            m_valid <= 1'b0;
                            m_last  <= 1'b0;
                            idx     <= 4'd0;
                            state   <= IDLE;
                        end else begin
                            m_data <= c_cap[idx_next[3:2]][idx_next[1:0]];
                            m_last <= (idx_next == 4'd15);
                            idx    <= idx_next;
                        end
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule
